// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and default parameters for the data-memory responder.
package dmem_pkg;

    localparam int DEFAULT_DEPTH_WORDS = 256;
    localparam int DEFAULT_WAIT_STATES = 2;

    localparam logic [1:0] LEN_BYTE    = 2'b00;
    localparam logic [1:0] LEN_HALF    = 2'b01;
    localparam logic [1:0] LEN_WORD    = 2'b10;
    localparam logic [1:0] LEN_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // An access is rejected if its size is illegal or it is not naturally aligned.
    function automatic logic access_error(input logic [1:0] length, input logic [1:0] addr_lo);
        logic err;
        case (length)
            LEN_BYTE: err = 1'b0;
            LEN_HALF: err = addr_lo[0];
            LEN_WORD: err = |addr_lo;
            default:  err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response handshake bus between an initiator and the data-memory responder.
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_length;
    logic        req_sign;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_length, req_sign, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_length, req_sign, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_load_align.sv
// Selects the addressed little-endian lanes of a memory word and sign/zero-extends them.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  length,
    input  logic        sign,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];
        case (length)
            LEN_BYTE: data = {{24{sign & byte_lane[7]}}, byte_lane};
            LEN_HALF: data = {{16{sign & half_lane[15]}}, half_lane};
            default:  data = word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: stores commit on acceptance, loads return
// after a fixed number of wait states and are held until the initiator consumes them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          sign_q, sign_d;
    logic [1:0]    len_q, len_d;
    logic [1:0]    lo_q, lo_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          accept;
    logic          enter_resp;
    logic [AW-1:0] live_idx;
    logic [1:0]    live_lo;
    logic          live_err;
    logic          act_we, act_sign, act_err;
    logic [1:0]    act_len, act_lo;
    logic [AW-1:0] act_idx;
    logic [31:0]   load_data;
    logic [3:0]    wr_be;
    logic [31:0]   wr_lanes;

    // Upper address bits fall away in the truncation, giving the modulo wrap.
    assign live_idx = AW'(bus.req_addr >> 2);
    assign live_lo  = bus.req_addr[1:0];
    assign live_err = access_error(bus.req_length, live_lo);
    assign accept   = bus.req_valid && (state_q == IDLE);

    // With zero wait states the read happens on the acceptance edge, so use live fields.
    assign act_we   = accept ? bus.req_we     : we_q;
    assign act_sign = accept ? bus.req_sign   : sign_q;
    assign act_len  = accept ? bus.req_length : len_q;
    assign act_lo   = accept ? live_lo        : lo_q;
    assign act_idx  = accept ? live_idx       : idx_q;
    assign act_err  = accept ? live_err       : err_q;

    assign enter_resp = (accept && (WAIT_STATES == 0)) || ((state_q == WAIT) && (cnt_q == 4'd0));

    dmem_load_align u_align (
        .word    (mem[act_idx]),
        .addr_lo (act_lo),
        .length  (act_len),
        .sign    (act_sign),
        .data    (load_data)
    );

    always_comb begin
        wr_be    = 4'b0000;
        wr_lanes = bus.req_wdata;
        case (bus.req_length)
            LEN_BYTE: begin
                wr_be    = 4'b0001 << live_lo;
                wr_lanes = {4{bus.req_wdata[7:0]}};
            end
            LEN_HALF: begin
                wr_be    = live_lo[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{bus.req_wdata[15:0]}};
            end
            LEN_WORD: wr_be = 4'b1111;
            default:  wr_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !live_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[live_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sign_d  = sign_q;
        len_d   = len_q;
        lo_d    = lo_q;
        idx_d   = idx_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d   = bus.req_we;
                    sign_d = bus.req_sign;
                    len_d  = bus.req_length;
                    lo_d   = live_lo;
                    idx_d  = live_idx;
                    err_d  = live_err;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) rdata_d = (act_we || act_err) ? 32'd0 : load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            len_q   <= 2'b00;
            lo_q    <= 2'b00;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sign_q  <= sign_d;
            len_q   <= len_d;
            lo_q    <= lo_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hold/reset sequences and randomized
// traffic checked against a byte-array reference model.
module tb_dmem_responder;

    localparam int WS_A = 2;
    localparam int WS_B = 0;

    logic clk;
    logic rst;

    dmem_if bus_a ();
    dmem_if bus_b ();

    logic        valid_a, valid_b;
    logic        t_we, t_sign, t_resp_ready;
    logic [31:0] t_addr, t_wdata;
    logic [1:0]  t_len;
    bit          cur_sel;

    int errors = 0;
    int checks = 0;

    logic [7:0] model [2][1024];

    assign bus_a.req_valid  = valid_a;
    assign bus_a.req_we     = t_we;
    assign bus_a.req_addr   = t_addr;
    assign bus_a.req_length = t_len;
    assign bus_a.req_sign   = t_sign;
    assign bus_a.req_wdata  = t_wdata;
    assign bus_a.resp_ready = t_resp_ready;
    assign bus_b.req_valid  = valid_b;
    assign bus_b.req_we     = t_we;
    assign bus_b.req_addr   = t_addr;
    assign bus_b.req_length = t_len;
    assign bus_b.req_sign   = t_sign;
    assign bus_b.req_wdata  = t_wdata;
    assign bus_b.resp_ready = t_resp_ready;

    logic        cur_ready, cur_resp_valid, cur_err;
    logic [31:0] cur_rdata;
    assign cur_ready      = cur_sel ? bus_b.req_ready  : bus_a.req_ready;
    assign cur_resp_valid = cur_sel ? bus_b.resp_valid : bus_a.resp_valid;
    assign cur_err        = cur_sel ? bus_b.resp_err   : bus_a.resp_err;
    assign cur_rdata      = cur_sel ? bus_b.resp_rdata : bus_a.resp_rdata;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        bit          sel;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  len;
        logic        sign;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [20];

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic modelErr(input logic [1:0] len, input logic [31:0] addr);
        return (len == 2'd3) || (len == 2'd1 && addr[0]) || (len == 2'd2 && addr[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] modelLoad(input bit sel, input logic [31:0] addr,
                                              input logic [1:0] len, input logic sign);
        int     b = int'(addr % 1024);
        int     n = nbytes(len);
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(model[sel][b + i]) << (8 * i);
        if (sign && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic modelStore(input bit sel, input logic [31:0] addr, input logic [1:0] len,
                              input logic [31:0] wdata);
        int b = int'(addr % 1024);
        for (int i = 0; i < nbytes(len); i++) model[sel][b + i] = wdata[8*i +: 8];
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One full transaction: accept, measure latency, check response, optionally stall, drain.
    task automatic applyStimulus(input bit sel, input logic we, input logic [31:0] addr,
                                 input logic [1:0] len, input logic sign, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int g = 0;
        int lat;
        int exp_lat = (sel ? WS_B : WS_A) + 1;
        cur_sel = sel;
        @(negedge clk);
        t_we = we; t_addr = addr; t_len = len; t_sign = sign; t_wdata = wdata;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        while (!cur_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!cur_ready) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            valid_a = 1'b0; valid_b = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        valid_a = 1'b0; valid_b = 1'b0;
        t_addr = $urandom; t_wdata = $urandom;
        lat = 1;
        while (!cur_resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'(exp_lat));
        if (!cur_resp_valid) return;
        checkOutput("rdata", 64'(cur_rdata), 64'(exp_rdata));
        checkOutput("err", 64'(cur_err), 64'(exp_err));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("hold_stable", {cur_resp_valid, cur_ready, cur_err, cur_rdata},
                        {1'b1, 1'b0, exp_err, exp_rdata});
        end
        @(negedge clk);
        t_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        t_resp_ready = 1'b0;
        checkOutput("back_to_idle", {cur_resp_valid, cur_ready}, 2'b01);
    endtask

    initial begin
        logic [31:0] d, a, er_data;
        logic [1:0]  ln;
        logic        w, s, er;
        int          seen;

        rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; t_resp_ready = 1'b0;
        t_we = 1'b0; t_addr = '0; t_len = '0; t_sign = 1'b0; t_wdata = '0;
        #3;
        cur_sel = 1'b0; #1;
        checkOutput("reset_a", {cur_ready, cur_resp_valid, cur_err, cur_rdata}, {1'b1, 1'b0, 1'b0, 32'd0});
        cur_sel = 1'b1; #1;
        checkOutput("reset_b", {cur_ready, cur_resp_valid, cur_err, cur_rdata}, {1'b1, 1'b0, 1'b0, 32'd0});
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        vecs[0]  = '{0, 1, 32'h10,  2'd2, 0, 32'hDEADBEEF, 32'h0,        0};
        vecs[1]  = '{0, 0, 32'h10,  2'd2, 0, 32'h0,        32'hDEADBEEF, 0};
        vecs[2]  = '{0, 0, 32'h13,  2'd0, 1, 32'h0,        32'hFFFFFFDE, 0};
        vecs[3]  = '{0, 0, 32'h13,  2'd0, 0, 32'h0,        32'h000000DE, 0};
        vecs[4]  = '{0, 0, 32'h10,  2'd1, 1, 32'h0,        32'hFFFFBEEF, 0};
        vecs[5]  = '{0, 1, 32'h11,  2'd0, 0, 32'hFFFFFF7F, 32'h0,        0};
        vecs[6]  = '{0, 0, 32'h10,  2'd2, 0, 32'h0,        32'hDEAD7FEF, 0};
        vecs[7]  = '{0, 1, 32'h11,  2'd1, 0, 32'h0000AAAA, 32'h0,        1};
        vecs[8]  = '{0, 0, 32'h10,  2'd2, 0, 32'h0,        32'hDEAD7FEF, 0};
        vecs[9]  = '{0, 0, 32'h12,  2'd1, 0, 32'h0,        32'h0000DEAD, 0};
        vecs[10] = '{0, 0, 32'h10,  2'd3, 0, 32'h0,        32'h0,        1};
        vecs[11] = '{0, 0, 32'h12,  2'd2, 0, 32'h0,        32'h0,        1};
        vecs[12] = '{0, 0, 32'h410, 2'd2, 0, 32'h0,        32'hDEAD7FEF, 0};
        vecs[13] = '{0, 1, 32'h12,  2'd1, 0, 32'hABCD8001, 32'h0,        0};
        vecs[14] = '{0, 0, 32'h10,  2'd2, 0, 32'h0,        32'h80017FEF, 0};
        vecs[15] = '{0, 0, 32'h12,  2'd1, 1, 32'h0,        32'hFFFF8001, 0};
        vecs[16] = '{1, 1, 32'h400, 2'd2, 0, 32'h12345678, 32'h0,        0};
        vecs[17] = '{1, 0, 32'h0,   2'd2, 0, 32'h0,        32'h12345678, 0};
        vecs[18] = '{1, 0, 32'h402, 2'd0, 0, 32'h0,        32'h00000034, 0};
        vecs[19] = '{1, 0, 32'h2,   2'd1, 1, 32'h0,        32'h00001234, 0};

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].len, vecs[i].sign,
                          vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, 0);
        end

        $display("[TB] response stall sequence");
        applyStimulus(0, 0, 32'h10, 2'd2, 0, 32'h0, 32'h80017FEF, 0, 5);

        $display("[TB] reset during wait sequence");
        cur_sel = 1'b0;
        @(negedge clk);
        t_we = 1'b1; t_addr = 32'h20; t_len = 2'd2; t_sign = 1'b0; t_wdata = 32'h55AA55AA;
        valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_wait", {cur_ready, cur_resp_valid, cur_err, cur_rdata}, {1'b1, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (cur_resp_valid) seen++;
        end
        checkOutput("abandoned_no_resp", 64'(seen), 64'd0);
        applyStimulus(0, 0, 32'h20, 2'd2, 0, 32'h0, 32'h55AA55AA, 0, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            modelStore(0, 32'(i * 4), 2'd2, d);
            applyStimulus(0, 1, 32'(i * 4), 2'd2, 0, d, 32'h0, 0, 0);
        end
        for (int n = 0; n < 250; n++) begin
            w  = 1'($urandom_range(0, 1));
            a  = $urandom;
            ln = 2'($urandom_range(0, 3));
            s  = 1'($urandom_range(0, 1));
            d  = $urandom;
            er = modelErr(ln, a);
            er_data = (w || er) ? 32'h0 : modelLoad(0, a, ln, s);
            if (w && !er) modelStore(0, a, ln, d);
            applyStimulus(0, w, a, ln, s, d, er_data, er, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words in the backing array; power of two.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, number of extra cycles between request acceptance and response; range 0..15.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 The block SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 The block SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr  input  32  byte address.
REQ-009 The block SHALL have port req_length  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 The block SHALL have port req_sign  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-011 The block SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-012 The block SHALL have port resp_valid  output  1  response available.
REQ-013 The block SHALL have port resp_ready  input  1  initiator consumes the response.
REQ-014 The block SHALL have port resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 The block SHALL have port resp_err  output  1  request was misaligned or had an illegal length.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP; req_ready = (state==IDLE); resp_valid = (state==RESP).
REQ-017 A request SHALL be accepted on the rising edge where req_valid && req_ready; all req_* fields are captured on that edge.
REQ-018 On acceptance: if WAIT_STATES==0 then next state = RESP, else next state = WAIT with counter loaded to WAIT_STATES-1.
REQ-019 In WAIT the counter SHALL decrement each cycle; at counter==0 the next state is RESP; first resp_valid cycle = acceptance edge + WAIT_STATES + 1.
REQ-020 In RESP, outputs SHALL hold stable until resp_ready is sampled high; then next state = IDLE; back-to-back requests need at least one IDLE cycle.
REQ-021 Word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-022 Misalignment is an error: half with addr[0]=1, word with addr[1:0]!=0, or length 11; the request still follows normal latency; resp_err=1, resp_rdata=0; stores do not modify the array.
REQ-023 Stores SHALL write on the acceptance edge, using little-endian lanes only: byte -> lane addr[1:0], half -> lanes addr[1]*2..+1, word -> all lanes; other bytes unchanged.
REQ-024 Loads SHALL read the selected lanes on the edge entering RESP, then extend: byte bit 7 / half bit 15 replicated if req_sign, else zero-filled; word unchanged.
REQ-025 A store followed by a load to the same word SHALL return the stored data; there is no read-during-write hazard because the store completes before the FSM returns to IDLE.
REQ-026 req_valid deasserting while req_ready is low SHALL have no effect; the initiator may change req_* while not accepted.

Reset
REQ-027 Asserting rst SHALL force, immediately: state IDLE, counter 0, captured request cleared, resp_rdata 0, resp_err 0; hence req_ready=1, resp_valid=0.
REQ-028 rst asserted mid-transaction (WAIT or RESP) SHALL abandon it with no response; a store already accepted stays written.
REQ-029 The array SHALL NOT be reset; contents are undefined until written.

Structure
REQ-030 Package dmem_pkg SHALL hold the length encodings (LEN_BYTE, LEN_HALF, LEN_WORD), the FSM state enum, and the default DEPTH_WORDS/WAIT_STATES constants.
REQ-031 Lane extraction and extension SHALL live in one combinational sub-module dmem_load_align (inputs word, addr[1:0], length, sign; output 32-bit data).

Verification
REQ-032 Bench: WAIT_STATES=2; store word 0xDEADBEEF @0x10; then load word @0x10 -> resp_valid 3 cycles after acceptance, rdata 0xDEADBEEF, err 0.
REQ-033 Bench: from previous state, load byte @0x13 sign=1 -> 0xFFFFFFDE; sign=0 -> 0x000000DE; load half @0x10 sign=1 -> 0xFFFFBEEF.
REQ-034 Bench: store byte 0x7F @0x11, then load word @0x10 -> 0xDEAD7FEF; store half @0x11 -> err=1, and a subsequent word load still reads 0xDEAD7FEF.
REQ-035 Bench: hold resp_ready low for 5 cycles in RESP -> resp_valid, rdata and err stable all 5 cycles, req_ready=0; on the 6th cycle resp_ready=1 -> IDLE next cycle.
REQ-036 Bench: assert rst during WAIT -> req_ready=1 and resp_valid=0 immediately, with no response ever issued for the abandoned request.
REQ-037 Bench: WAIT_STATES=0, DEPTH_WORDS=256; store word 0x12345678 @0x400 (wraps to 0x000) -> load @0x0 returns 0x12345678, 1 cycle after acceptance.
